// File: rtl/block_uart_tx.sv
// block_uart_tx: sends one accepted 128-bit block as 16 UART frames on txd, byte 0 first.
// Define BLOCK_UART_TX_PARITY_EN to insert an even-parity bit after each byte's data bits.
module block_uart_tx #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int GAP_BITS     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] blk_data,
   input  logic         blk_valid,
   output logic         blk_ready,
   output logic         txd,
   output logic         busy,
   output logic [3:0]   byte_idx,
   output logic         done
);

   localparam int GAP_CLKS = (GAP_BITS > 0) ? GAP_BITS * CLKS_PER_BIT : 1;
   localparam int MAX_CNT  = (GAP_CLKS > CLKS_PER_BIT) ? GAP_CLKS : CLKS_PER_BIT;
   localparam int CNT_W    = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CLKS - 1);

`ifdef BLOCK_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`endif

   state_t             state, state_n;
   logic [CNT_W-1:0]   baud_cnt, baud_n;
   logic [2:0]         bit_cnt, bit_n;
   logic [127:0]       shift_reg, shift_n;
   logic [3:0]         idx_n;
   logic               busy_n, done_n, txd_n;
   logic [7:0]         cur_byte_n;
   logic               bit_end, gap_end;

   assign blk_ready = (state == IDLE);
   assign bit_end   = (baud_cnt == BIT_LAST);
   assign gap_end   = (baud_cnt == GAP_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         byte_idx  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         txd       <= 1'b1;
      end else begin
         state     <= state_n;
         baud_cnt  <= baud_n;
         bit_cnt   <= bit_n;
         shift_reg <= shift_n;
         byte_idx  <= idx_n;
         busy      <= busy_n;
         done      <= done_n;
         txd       <= txd_n;
      end
   end

   // Next-state decode; txd is registered from the state being entered so it lines up with state.
   always_comb begin
      state_n = state;
      baud_n  = baud_cnt + CNT_W'(1);
      bit_n   = bit_cnt;
      shift_n = shift_reg;
      idx_n   = byte_idx;
      busy_n  = busy;
      done_n  = 1'b0;

      case (state)
         IDLE: begin
            baud_n = '0;
            if (blk_valid) begin
               shift_n = blk_data;
               state_n = START;
               busy_n  = 1'b1;
               idx_n   = 4'd0;
               bit_n   = 3'd0;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               baud_n  = '0;
               bit_n   = 3'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_n = '0;
               if (bit_cnt == 3'd7) begin
`ifdef BLOCK_UART_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_cnt + 3'd1;
               end
            end
         end
`ifdef BLOCK_UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_n = STOP;
               baud_n  = '0;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               baud_n = '0;
               if (byte_idx == 4'd15) begin
                  state_n = IDLE;
                  done_n  = 1'b1;
                  busy_n  = 1'b0;
                  idx_n   = 4'd0;
               end else if (GAP_BITS > 0) begin
                  state_n = GAP;
               end else begin
                  state_n = START;
                  idx_n   = byte_idx + 4'd1;
                  shift_n = {8'h00, shift_reg[127:8]};
               end
            end
         end
         GAP: begin
            if (gap_end) begin
               state_n = START;
               baud_n  = '0;
               idx_n   = byte_idx + 4'd1;
               shift_n = {8'h00, shift_reg[127:8]};
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
         end
      endcase

      cur_byte_n = shift_n[7:0];
      case (state_n)
         START:   txd_n = 1'b0;
         DATA:    txd_n = cur_byte_n[bit_n];
`ifdef BLOCK_UART_TX_PARITY_EN
         PARITY:  txd_n = even_parity(cur_byte_n);
`endif
         default: txd_n = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_block_uart_tx.sv
// Bench for block_uart_tx: two instances (GAP_BITS=1 and GAP_BITS=0), queue scoreboard fed by a txd decoder.
`timescale 1ns/1ps
module tb_block_uart_tx;

   localparam int C = 4;
`ifdef BLOCK_UART_TX_PARITY_EN
   localparam int FRAME = 11;
`else
   localparam int FRAME = 10;
`endif
   localparam int DUR0 = 16*FRAME*C + 15*C;
   localparam int DUR1 = 16*FRAME*C;
   localparam int SP0  = (FRAME + 1)*C;
   localparam int SP1  = FRAME*C;

   logic         clk = 1'b0;
   logic [1:0]   rst;
   logic [1:0]   blk_valid, blk_ready, txd, busy, done;
   logic [127:0] blk_data0, blk_data1;
   logic [3:0]   byte_idx0, byte_idx1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [127:0] bq0[$];
   logic [127:0] bq1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   block_uart_tx #(.CLKS_PER_BIT(C), .GAP_BITS(1)) dut0 (
      .clk(clk), .rst(rst[0]), .blk_data(blk_data0), .blk_valid(blk_valid[0]),
      .blk_ready(blk_ready[0]), .txd(txd[0]), .busy(busy[0]), .byte_idx(byte_idx0), .done(done[0])
   );

   block_uart_tx #(.CLKS_PER_BIT(C), .GAP_BITS(0)) dut1 (
      .clk(clk), .rst(rst[1]), .blk_data(blk_data1), .blk_valid(blk_valid[1]),
      .blk_ready(blk_ready[1]), .txd(txd[1]), .busy(busy[1]), .byte_idx(byte_idx1), .done(done[1])
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int q_size(input int i);
      return (i == 0) ? bq0.size() : bq1.size();
   endfunction

   function automatic logic [127:0] q_front(input int i);
      return (i == 0) ? bq0[0] : bq1[0];
   endfunction

   task automatic q_push(input int i, input logic [127:0] d);
      if (i == 0) bq0.push_back(d); else bq1.push_back(d);
   endtask

   task automatic q_pop(input int i);
      if (i == 0) void'(bq0.pop_front()); else void'(bq1.pop_front());
   endtask

   task automatic q_clear(input int i);
      if (i == 0) bq0.delete(); else bq1.delete();
   endtask

   // Monitor: decodes txd of each instance mid-bit and checks bytes, frame spacing and done timing.
   int         rx_cnt[2], rx_n[2], blk_t0[2], frm_t0[2];
   logic       rx_act[2];
   logic [7:0] rx_byte[2];
   logic       rx_par[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         rx_cnt[i] = 0; rx_n[i] = 0; blk_t0[i] = 0; frm_t0[i] = 0;
         rx_act[i] = 1'b0; rx_byte[i] = 8'h00; rx_par[i] = 1'b0;
      end
   end

   always @(negedge clk) begin : monitor
      int k;
      logic [127:0] fb;
      logic [7:0] eb;
      for (int i = 0; i < 2; i++) begin
         if (rst[i] === 1'b1) begin
            rx_act[i] = 1'b0;
            rx_n[i]   = 0;
            q_clear(i);
         end else begin
            if (done[i] === 1'b1) begin
               check($sformatf("done_has_block_%0d", i), int'(q_size(i) > 0), 1);
               check($sformatf("done_busy_low_%0d", i), int'(busy[i]), 0);
               if (q_size(i) > 0) begin
                  check($sformatf("done_frames_%0d", i), rx_n[i], 16);
                  check($sformatf("done_time_%0d", i), cyc - blk_t0[i], (i == 0) ? DUR0 : DUR1);
                  q_pop(i);
               end
               rx_n[i] = 0;
            end
            if (!rx_act[i]) begin
               if (txd[i] === 1'b0) begin
                  rx_act[i] = 1'b1;
                  rx_cnt[i] = 0;
                  if (rx_n[i] == 0) blk_t0[i] = cyc;
                  else check($sformatf("frame_spacing_%0d", i), cyc - frm_t0[i], (i == 0) ? SP0 : SP1);
                  frm_t0[i] = cyc;
               end
            end else begin
               rx_cnt[i]++;
               if (rx_cnt[i] % C == C/2) begin
                  k = rx_cnt[i] / C;
                  if (k == 0) begin
                     check($sformatf("start_bit_%0d", i), int'(txd[i]), 0);
                  end else if (k == FRAME - 1) begin
                     check($sformatf("stop_bit_%0d", i), int'(txd[i]), 1);
                     check($sformatf("frame_in_block_%0d", i), int'(q_size(i) > 0 && rx_n[i] < 16), 1);
                     if (q_size(i) > 0 && rx_n[i] < 16) begin
                        fb = q_front(i);
                        eb = fb[rx_n[i]*8 +: 8];
                        check($sformatf("byte_%0d_%0d", i, rx_n[i]), int'(rx_byte[i]), int'(eb));
`ifdef BLOCK_UART_TX_PARITY_EN
                        check($sformatf("parity_%0d_%0d", i, rx_n[i]), int'(rx_par[i]), int'(^eb));
`endif
                     end
                     rx_n[i]++;
                     rx_act[i] = 1'b0;
                  end else if (k >= 1 && k <= 8) begin
                     rx_byte[i][3'(k - 1)] = txd[i];
                  end else if (k == 9) begin
                     rx_par[i] = txd[i];
                  end
               end
            end
         end
      end
   end

   task automatic send(input int i, input logic [127:0] d);
      int n;
      n = 0;
      while (blk_ready[i] !== 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("send_ready_%0d", i), int'(blk_ready[i]), 1);
      @(posedge clk); #1;
      if (i == 0) blk_data0 = d; else blk_data1 = d;
      q_push(i, d);
      blk_valid[i] = 1'b1;
      @(posedge clk); #1;
      blk_valid[i] = 1'b0;
   endtask

   task automatic wait_done(input int i);
      int n;
      logic got;
      n = 0;
      got = 1'b0;
      while (!got && n < 3000) begin
         @(negedge clk);
         if (done[i] === 1'b1) got = 1'b1;
         n++;
      end
      check($sformatf("done_seen_%0d", i), int'(got), 1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int n, ready_hi, dones;
      logic got;
      rst       = 2'b11;
      blk_valid = 2'b00;
      blk_data0 = '0;
      blk_data1 = '0;
      repeat (2) @(posedge clk);
      #1 rst = 2'b00;
      @(negedge clk);
      check("rst_txd", int'(txd[0]), 1);
      check("rst_busy", int'(busy[0]), 0);
      check("rst_ready", int'(blk_ready[0]), 1);
      check("rst_idx", int'(byte_idx0), 0);
      check("rst_done", int'(done[0]), 0);
      check("rst_txd_g0", int'(txd[1]), 1);

      // Single block, GAP_BITS=1
      send(0, 128'h48656c6c6f2044722e20416465656c21);
      @(negedge clk);
      check("t1_start_latency", int'(txd[0]), 0);
      check("t1_busy", int'(busy[0]), 1);
      check("t1_ready_low", int'(blk_ready[0]), 0);
      check("t1_idx", int'(byte_idx0), 0);
      wait_done(0);

      // Valid held high with changing data; second block accepted in the done cycle
      @(posedge clk); #1;
      blk_data0 = 128'h00112233445566778899aabbccddeeff;
      q_push(0, blk_data0);
      blk_valid[0] = 1'b1;
      @(posedge clk); #1;
      blk_data0 = 128'hffeeddccbbaa99887766554433221100;
      ready_hi = 0;
      got = 1'b0;
      n = 0;
      while (!got && n < 3000) begin
         @(negedge clk);
         if (done[0] === 1'b1) got = 1'b1;
         else if (blk_ready[0] !== 1'b0) ready_hi++;
         n++;
      end
      check("t2_done_seen", int'(got), 1);
      check("t2_ready_low_while_busy", ready_hi, 0);
      check("t2_ready_in_done", int'(blk_ready[0]), 1);
      check("t2_txd_idle_in_done", int'(txd[0]), 1);
      q_push(0, blk_data0);
      @(posedge clk); #1;
      blk_valid[0] = 1'b0;
      @(negedge clk);
      check("t2_second_start", int'(txd[0]), 0);
      check("t2_second_busy", int'(busy[0]), 1);
      wait_done(0);

      // Back-to-back frames, GAP_BITS=0
      send(1, 128'h5a5aa5a50f0ff0f013579bdf02468ace);
      @(negedge clk);
      check("t3_start_latency", int'(txd[1]), 0);
      wait_done(1);

      // Reset in the middle of byte 5
      send(0, 128'hdeadbeefcafebabe0123456789abcdef);
      n = 0;
      while (byte_idx0 !== 4'd5 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("t4_reached_idx5", int'(byte_idx0), 5);
      repeat (6) @(posedge clk);
      #1 rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      @(negedge clk);
      check("t4_txd", int'(txd[0]), 1);
      check("t4_busy", int'(busy[0]), 0);
      check("t4_ready", int'(blk_ready[0]), 1);
      check("t4_idx", int'(byte_idx0), 0);
      dones = 0;
      repeat (800) begin
         @(negedge clk);
         if (done[0] === 1'b1) dones++;
      end
      check("t4_no_done", dones, 0);

      // Byte 0 = 0x07, byte 1 = 0x6c (odd / even population)
      send(0, 128'h0123456789abcdeffedcba9876546c07);
      wait_done(0);

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
